sha256_msg_padder: RTL and testbench

//  Upstream feeder for the SHA-256 control FSM. Accepts a byte-aligned message as 32-bit big-endian words.

---
 rtl/sha256_pkg.sv | 30 +++
 rtl/sha256_blk_buf.sv | 29 ++
 rtl/sha256_msg_padder.sv | 187 ++++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message padder: state encoding, block geometry
// and the byte-level marker insertion used on a message's final word.
package sha256_pkg;

    localparam int          LEN_W       = 64;
    localparam int          BLK_WORDS   = 16;
    localparam logic [31:0] MARKER      = 32'h8000_0000;
    localparam logic [3:0]  LEN_SLOT_HI = 4'd14;
    localparam logic [3:0]  LEN_SLOT_LO = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_PAD,
        ST_SEND,
        ST_WAIT
    } pad_state_e;

    // Keeps the first nb bytes of a tail word and appends the 0x80 marker byte.
    function automatic logic [31:0] pad_word(input logic [31:0] d, input logic [2:0] nb);
        case (nb)
            3'd0:    pad_word = MARKER;
            3'd1:    pad_word = {d[31:24], 8'h80, 16'h0000};
            3'd2:    pad_word = {d[31:16], 8'h80, 8'h00};
            3'd3:    pad_word = {d[31:8], 8'h80};
            default: pad_word = d;
        endcase
    endfunction

endpackage

// File: rtl/sha256_blk_buf.sv
// 16x32 block buffer: one write port, one combinational read port, synchronous clear-all.
// A write in the same cycle as a clear lands on top of the cleared contents.
module sha256_blk_buf
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        we,
    input  logic [3:0]  widx,
    input  logic [31:0] wdata,
    input  logic [3:0]  ridx,
    output logic [31:0] rdata
);

    logic [BLK_WORDS-1:0][31:0] mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else begin
            if (clr) mem <= '0;
            if (we)  mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/sha256_msg_padder.sv
// FIPS 180-4 message padder: buffers 32-bit message words into 512-bit blocks, inserts the
// marker and 64-bit bit length, and streams each block to the compression core in 16 cycles.
module sha256_msg_padder
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [2:0]  in_nbytes,
    output logic        start,
    output logic        data_valid,
    output logic [31:0] data_out,
    output logic        last_block,
    input  logic        blk_done,
    output logic        busy
);

    pad_state_e       state, state_n;
    logic [3:0]       idx, idx_n;
    logic [LEN_W-1:0] bitcnt, bitcnt_n;
    logic [4:0]       scnt, scnt_n;
    logic             last_blk, last_blk_n;
    logic             pend_len, pend_len_n;     // length needs a block of its own
    logic             pend_mark, pend_mark_n;   // marker spills into the next block
    logic             mark_pend, mark_pend_n;   // PAD writes the marker before zero fill
    logic             len_in_blk, len_in_blk_n;
    logic             first_blk, first_blk_n;
    logic             ready_en;

    logic             we, clr, xfer;
    logic [3:0]       widx, ridx;
    logic [31:0]      wdata, rdata;

    sha256_blk_buf u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .we    (we),
        .widx  (widx),
        .wdata (wdata),
        .ridx  (ridx),
        .rdata (rdata)
    );

    // Holds in_ready low through reset and the first cycle after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    assign in_ready   = ready_en && (state == ST_IDLE || state == ST_FILL);
    assign xfer       = in_valid && in_ready;
    assign ridx       = 4'(scnt - 5'd1);
    assign data_valid = (state == ST_SEND) && (scnt != 5'd0);
    assign start      = (state == ST_SEND) && (scnt == 5'd0) && first_blk;
    assign data_out   = data_valid ? rdata : 32'h0;
    assign last_block = (state == ST_SEND) && last_blk;
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            bitcnt     <= '0;
            scnt       <= '0;
            last_blk   <= 1'b0;
            pend_len   <= 1'b0;
            pend_mark  <= 1'b0;
            mark_pend  <= 1'b0;
            len_in_blk <= 1'b0;
            first_blk  <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            bitcnt     <= bitcnt_n;
            scnt       <= scnt_n;
            last_blk   <= last_blk_n;
            pend_len   <= pend_len_n;
            pend_mark  <= pend_mark_n;
            mark_pend  <= mark_pend_n;
            len_in_blk <= len_in_blk_n;
            first_blk  <= first_blk_n;
        end
    end

    always_comb begin
        state_n      = state;
        idx_n        = idx;
        bitcnt_n     = bitcnt;
        scnt_n       = scnt;
        last_blk_n   = last_blk;
        pend_len_n   = pend_len;
        pend_mark_n  = pend_mark;
        mark_pend_n  = mark_pend;
        len_in_blk_n = len_in_blk;
        first_blk_n  = first_blk;
        we           = 1'b0;
        clr          = 1'b0;
        widx         = idx;
        wdata        = 32'h0;
        case (state)
            ST_IDLE, ST_FILL: begin
                if (state == ST_IDLE) first_blk_n = 1'b1;
                if (xfer) begin
                    we      = 1'b1;
                    idx_n   = idx + 4'd1;
                    state_n = ST_FILL;
                    if (!in_last) begin
                        wdata    = in_data;
                        bitcnt_n = bitcnt + 64'd32;
                        if (idx == 4'd15) state_n = ST_SEND;
                    end else if (in_nbytes >= 3'd4) begin
                        wdata    = in_data;
                        bitcnt_n = bitcnt + 64'd32;
                        if (idx == 4'd15) begin
                            state_n     = ST_SEND;
                            pend_mark_n = 1'b1;
                        end else begin
                            state_n      = ST_PAD;
                            mark_pend_n  = 1'b1;
                            len_in_blk_n = (idx <= 4'd12);
                        end
                    end else begin
                        wdata    = pad_word(in_data, in_nbytes);
                        bitcnt_n = bitcnt + LEN_W'({in_nbytes, 3'b000});
                        if (idx == 4'd15) begin
                            state_n    = ST_SEND;
                            pend_len_n = 1'b1;
                        end else begin
                            state_n      = ST_PAD;
                            len_in_blk_n = (idx <= 4'd13);
                        end
                    end
                end
            end
            ST_PAD: begin
                we          = 1'b1;
                idx_n       = idx + 4'd1;
                mark_pend_n = 1'b0;
                if (mark_pend)                               wdata = MARKER;
                else if (len_in_blk && idx == LEN_SLOT_HI)   wdata = bitcnt[LEN_W-1:32];
                else if (len_in_blk && idx == LEN_SLOT_LO)   wdata = bitcnt[31:0];
                if (idx == 4'd15) begin
                    state_n = ST_SEND;
                    if (len_in_blk) last_blk_n = 1'b1;
                    else            pend_len_n = 1'b1;
                end
            end
            ST_SEND: begin
                scnt_n = scnt + 5'd1;
                if (scnt == 5'd16) begin
                    scnt_n      = '0;
                    first_blk_n = 1'b0;
                    state_n     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (blk_done) begin
                    idx_n = '0;
                    if (pend_len || pend_mark) begin
                        // Trailing block: zeros, optional marker at slot 0, length at 14/15.
                        clr          = 1'b1;
                        state_n      = ST_PAD;
                        last_blk_n   = 1'b0;
                        len_in_blk_n = 1'b1;
                        mark_pend_n  = pend_mark;
                        pend_len_n   = 1'b0;
                        pend_mark_n  = 1'b0;
                        if (pend_len) idx_n = LEN_SLOT_HI;
                    end else if (last_blk) begin
                        state_n      = ST_IDLE;
                        bitcnt_n     = '0;
                        last_blk_n   = 1'b0;
                        len_in_blk_n = 1'b0;
                    end else begin
                        state_n = ST_FILL;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: table of messages with hand-computed padded blocks,
// plus reset, stray blk_done and mid-send reset sequences.
module tb_sha256_msg_padder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        blk_done = 1'b0;
    logic [31:0] in_data = '0;
    logic [2:0]  in_nbytes = '0;
    logic        in_ready, start, data_valid, last_block, busy;
    logic [31:0] data_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sha256_msg_padder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_nbytes  (in_nbytes),
        .start      (start),
        .data_valid (data_valid),
        .data_out   (data_out),
        .last_block (last_block),
        .blk_done   (blk_done),
        .busy       (busy)
    );

    typedef struct {
        int                        nw;
        logic [2:0]                nb;
        logic [31:0]               ld;
        bit                        gap;
        int                        nblk;
        logic [1:0]                exp_last;
        logic [1:0][15:0][31:0]    exp;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs [NVEC];

    function automatic logic [31:0] mw(input int i);
        return {8'hA5, 8'(i), 8'h5A, 8'(i)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event within cycle budget", name);
    endtask

    task automatic setv(input int id, input int nw, input logic [2:0] nb, input logic [31:0] ld,
                        input bit gap, input int nblk, input logic [1:0] el);
        vecs[id].nw       = nw;
        vecs[id].nb       = nb;
        vecs[id].ld       = ld;
        vecs[id].gap      = gap;
        vecs[id].nblk     = nblk;
        vecs[id].exp_last = el;
        vecs[id].exp      = '0;
        for (int i = 0; i < nw - 1; i++) vecs[id].exp[0][i] = mw(i);
    endtask

    task automatic drive_msg(input vec_t v);
        int   t;
        logic ok;
        for (int i = 0; i < v.nw; i++) begin
            if (v.gap && i > 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid  = 1'b1;
            in_last   = (i == v.nw - 1);
            in_data   = in_last ? v.ld : mw(i);
            in_nbytes = in_last ? v.nb : 3'd4;
            t = 0;
            forever begin
                ok = in_ready;
                @(posedge clk); #1;
                if (ok) break;
                t++;
                if (t > 500) begin
                    timeout("drive_ready");
                    break;
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic monitor(input int id, input vec_t v);
        int blk = 0, k = 0, cyc = 0, starts = 0, gaps = 0, early = 0;
        logic [1:0][15:0][31:0] got;
        got = '0;
        while (blk < v.nblk && cyc < 800) begin
            @(negedge clk);
            cyc++;
            if (start) starts++;
            if (data_valid) begin
                got[blk][k] = data_out;
                chk($sformatf("v%0d blk%0d w%0d last_block", id, blk, k), last_block, v.exp_last[blk]);
                k++;
                if (k == 16) begin
                    k = 0;
                    blk++;
                    repeat (2) begin
                        @(negedge clk);
                        if (data_valid) early++;
                    end
                    chk($sformatf("v%0d blk%0d busy_before_done", id, blk - 1), busy, 1);
                    blk_done = 1'b1;
                    @(negedge clk);
                    blk_done = 1'b0;
                    if (blk == v.nblk)
                        chk($sformatf("v%0d busy_after_final_done", id), busy, 0);
                end
            end else if (k != 0) begin
                gaps++;
            end
        end
        if (blk < v.nblk) timeout($sformatf("v%0d blocks", id));
        for (int b = 0; b < v.nblk; b++)
            for (int w = 0; w < 16; w++)
                chk($sformatf("v%0d blk%0d w%0d data", id, b, w), got[b][w], v.exp[b][w]);
        chk($sformatf("v%0d start_pulses", id), starts, 1);
        chk($sformatf("v%0d burst_gaps", id), gaps, 0);
        chk($sformatf("v%0d data_before_done", id), early, 0);
    endtask

    task automatic run_vec(input int id);
        vec_t v;
        v = vecs[id];
        fork
            drive_msg(v);
            monitor(id, v);
        join
    endtask

    initial begin
        int cnt, cyc;

        // "abc"
        setv(0, 1, 3'd3, 32'h6162_6300, 1'b0, 1, 2'b01);
        vecs[0].exp[0][0]  = 32'h6162_6380;
        vecs[0].exp[0][15] = 32'h0000_0018;
        // empty message, tail data must be ignored
        setv(1, 1, 3'd0, 32'hDEAD_BEEF, 1'b0, 1, 2'b01);
        vecs[1].exp[0][0]  = 32'h8000_0000;
        // 55 bytes
        setv(2, 14, 3'd3, 32'h1122_3344, 1'b0, 1, 2'b01);
        vecs[2].exp[0][13] = 32'h1122_3380;
        vecs[2].exp[0][15] = 32'h0000_01B8;
        // 56 bytes: marker at slot 14, length spills
        setv(3, 14, 3'd4, 32'h1122_3344, 1'b0, 2, 2'b10);
        vecs[3].exp[0][13] = 32'h1122_3344;
        vecs[3].exp[0][14] = 32'h8000_0000;
        vecs[3].exp[1][15] = 32'h0000_01C0;
        // 64 bytes with upstream gaps: marker spills into block 2
        setv(4, 16, 3'd4, 32'h5566_7788, 1'b1, 2, 2'b10);
        vecs[4].exp[0][15] = 32'h5566_7788;
        vecs[4].exp[1][0]  = 32'h8000_0000;
        vecs[4].exp[1][15] = 32'h0000_0200;
        // 57 bytes: marker byte in slot 14
        setv(5, 15, 3'd1, 32'hAABB_CCDD, 1'b0, 2, 2'b10);
        vecs[5].exp[0][14] = 32'hAA80_0000;
        vecs[5].exp[1][15] = 32'h0000_01C8;
        // 2 bytes, with a gap pattern that never triggers
        setv(6, 1, 3'd2, 32'hAABB_CCDD, 1'b1, 1, 2'b01);
        vecs[6].exp[0][0]  = 32'hAABB_8000;
        vecs[6].exp[0][15] = 32'h0000_0010;
        // 60 bytes: marker word in slot 15
        setv(7, 15, 3'd4, 32'h0102_0304, 1'b0, 2, 2'b10);
        vecs[7].exp[0][14] = 32'h0102_0304;
        vecs[7].exp[0][15] = 32'h8000_0000;
        vecs[7].exp[1][15] = 32'h0000_01E0;

        repeat (2) @(negedge clk);
        chk("reset in_ready", in_ready, 0);
        chk("reset start", start, 0);
        chk("reset data_valid", data_valid, 0);
        chk("reset data_out", data_out, 0);
        chk("reset last_block", last_block, 0);
        chk("reset busy", busy, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle in_ready", in_ready, 1);

        // stray blk_done while idle
        blk_done = 1'b1;
        @(negedge clk);
        blk_done = 1'b0;
        @(negedge clk);
        chk("stray_done busy", busy, 0);
        chk("stray_done data_valid", data_valid, 0);

        for (int i = 0; i < NVEC; i++) run_vec(i);

        // reset while word 7 of "abc" is on the output
        drive_msg(vecs[0]);
        cnt = 0;
        cyc = 0;
        while (cnt < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (data_valid) cnt++;
        end
        if (cnt < 8) begin
            timeout("midsend word7");
        end else begin
            chk("midsend busy_before", busy, 1);
            #1 rst_n = 1'b0;
            #1;
            chk("midsend data_valid", data_valid, 0);
            chk("midsend busy", busy, 0);
            chk("midsend last_block", last_block, 0);
            chk("midsend data_out", data_out, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_vec(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
